// File: rtl/ovf_adj_pkg.sv
// Shared constants, FSM state type and lane-index width helper for the
// overflow adjust scheduler.
package ovf_adj_pkg;

    localparam int unsigned LSP_WIDTH = 18;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    function automatic int unsigned lane_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ovf_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting lane at or
// after ptr, wrapping around.
module ovf_rr_arbiter
    import ovf_adj_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [lane_w(N)-1:0]   ptr,
    output logic [N-1:0]           grant,
    output logic [lane_w(N)-1:0]   idx,
    output logic                   any_req
);

    localparam int unsigned LW = lane_w(N);

    logic [LW-1:0] cand;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = LW'((32'(ptr) + i) % N);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                idx     = cand;
            end
        end
        if (any_req) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/overflow_adjust_scheduler.sv
// Shares one LSP/MSP overflow-split datapath among N_LANES accumulator lanes.
// Optional statistics counters are enabled by defining OVF_ADJ_STATS_EN.
module overflow_adjust_scheduler
    import ovf_adj_pkg::*;
#(
    parameter int unsigned ACCUM_WIDTH = 48,
    parameter int unsigned N_LANES     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_LANES-1:0]               req_valid,
    input  logic [N_LANES*ACCUM_WIDTH-1:0]   req_data,
    output logic [N_LANES-1:0]               req_ready,
    output logic                             lsp_valid,
    input  logic                             lsp_ready,
    output logic [lane_w(N_LANES)-1:0]       lsp_lane,
    output logic [ACCUM_WIDTH-1:0]           lsp_data,
    output logic                             msp_valid,
    input  logic                             msp_ready,
    output logic [lane_w(N_LANES)-1:0]       msp_lane,
    output logic [ACCUM_WIDTH-1:0]           msp_data,
    output logic                             busy
`ifdef OVF_ADJ_STATS_EN
    ,
    output logic [31:0]                      adj_count,
    output logic [31:0]                      msp_nz_count
`endif
);

    localparam int unsigned LW = lane_w(N_LANES);

    state_e                 state_q, state_d;
    logic [LW-1:0]          ptr_q, ptr_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [ACCUM_WIDTH-1:0] data_q, data_d;
    logic                   lsp_pend_q, lsp_pend_d;
    logic                   msp_pend_q, msp_pend_d;

    logic [N_LANES-1:0]     grant;
    logic [LW-1:0]          gnt_idx;
    logic                   any_req;
    logic [ACCUM_WIDTH-1:0] sel_data;

    ovf_rr_arbiter #(
        .N (N_LANES)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .idx     (gnt_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lane_d     = lane_q;
        data_d     = data_q;
        lsp_pend_d = lsp_pend_q;
        msp_pend_d = msp_pend_q;
        req_ready  = '0;
        sel_data   = req_data[gnt_idx*ACCUM_WIDTH +: ACCUM_WIDTH];

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready  = grant;
                    lane_d     = gnt_idx;
                    data_d     = sel_data;
                    ptr_d      = (gnt_idx == LW'(N_LANES - 1)) ? '0 : gnt_idx + 1'b1;
                    lsp_pend_d = 1'b1;
                    // A zero MSP has nothing to add, so that channel starts out done.
                    msp_pend_d = |sel_data[ACCUM_WIDTH-1:LSP_WIDTH];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                lsp_pend_d = lsp_pend_q && !lsp_ready;
                msp_pend_d = msp_pend_q && !msp_ready;
                if (!lsp_pend_d && !msp_pend_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            lane_q     <= '0;
            data_q     <= '0;
            lsp_pend_q <= 1'b0;
            msp_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lane_q     <= lane_d;
            data_q     <= data_d;
            lsp_pend_q <= lsp_pend_d;
            msp_pend_q <= msp_pend_d;
        end
    end

    // Lane/data outputs read as zero whenever their channel is not valid.
    assign lsp_valid = lsp_pend_q;
    assign msp_valid = msp_pend_q;
    assign lsp_lane  = lsp_pend_q ? lane_q : '0;
    assign msp_lane  = msp_pend_q ? lane_q : '0;
    assign lsp_data  = lsp_pend_q ? ACCUM_WIDTH'(data_q[LSP_WIDTH-1:0]) : '0;
    assign msp_data  = msp_pend_q ? ACCUM_WIDTH'(data_q[ACCUM_WIDTH-1:LSP_WIDTH]) : '0;
    assign busy      = (state_q == ISSUE);

`ifdef OVF_ADJ_STATS_EN
    logic [31:0] adj_count_q, adj_count_d;
    logic [31:0] msp_nz_count_q, msp_nz_count_d;

    always_comb begin
        adj_count_d    = adj_count_q;
        msp_nz_count_d = msp_nz_count_q;
        if ((state_q == ISSUE) && (state_d == IDLE) && (adj_count_q != '1)) begin
            adj_count_d = adj_count_q + 32'd1;
        end
        if (msp_pend_q && msp_ready && (msp_nz_count_q != '1)) begin
            msp_nz_count_d = msp_nz_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adj_count_q    <= '0;
            msp_nz_count_q <= '0;
        end else begin
            adj_count_q    <= adj_count_d;
            msp_nz_count_q <= msp_nz_count_d;
        end
    end

    assign adj_count    = adj_count_q;
    assign msp_nz_count = msp_nz_count_q;
`endif

endmodule
